// File: rtl/mult_arbiter.sv
// rtl/mult_arbiter.sv - round-robin arbiter sequencing one shared 4-phase multiplier
module mult_arbiter #(
  parameter int N_REQ       = 4,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [N_REQ-1:0]        req_i,
  input  logic [N_REQ*DATA_W-1:0] a_i,
  input  logic [N_REQ*DATA_W-1:0] b_i,
  output logic [N_REQ-1:0]        gnt_o,
  output logic [N_REQ-1:0]        done_o,
  output logic [2*DATA_W-1:0]     prod_o,
  output logic                    err_o,
  output logic                    busy_o,
  output logic                    mul_strt_o,
  output logic [DATA_W-1:0]       mul_a_o,
  output logic [DATA_W-1:0]       mul_b_o,
  input  logic [2:0]              mul_state_i,
  input  logic [2*DATA_W-1:0]     mul_prod_i
);

  // Multiplier state codes: IDLE=0, COMPUTE_PROD0..3=1..4, END=5
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_END  = 3'd5;
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    A_IDLE    = 2'd0,
    A_WAIT    = 2'd1,
    A_RELEASE = 2'd2
  } arb_state_t;

  arb_state_t             state_q, state_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [N_REQ-1:0]       gnt_d, done_d;
  logic [2*DATA_W-1:0]    prod_d;
  logic                   err_d, busy_d, strt_d;
  logic [DATA_W-1:0]      a_d, b_d;
  logic                   sel_vld;
  logic [PTR_W-1:0]       sel_idx;

  function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return PTR_W'(s);
  endfunction

  // Scan downward so the last hit is the one closest to ptr going upward.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_i[wrap_idx(ptr_q, i)]) begin
        sel_vld = 1'b1;
        sel_idx = wrap_idx(ptr_q, i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_o;
    done_d  = '0;
    prod_d  = prod_o;
    err_d   = err_o;
    busy_d  = busy_o;
    strt_d  = mul_strt_o;
    a_d     = mul_a_o;
    b_d     = mul_b_o;
    case (state_q)
      A_IDLE: begin
        if (mul_state_i == ST_IDLE && sel_vld) begin
          gnt_d          = '0;
          gnt_d[sel_idx] = 1'b1;
          a_d            = a_i[sel_idx*DATA_W +: DATA_W];
          b_d            = b_i[sel_idx*DATA_W +: DATA_W];
          ptr_d          = wrap_idx(sel_idx, 1);
          cnt_d          = '0;
          busy_d         = 1'b1;
          strt_d         = 1'b1;
          state_d        = A_WAIT;
        end
      end
      A_WAIT: begin
        if (mul_state_i == ST_END) begin
          prod_d  = mul_prod_i;
          done_d  = gnt_o;
          strt_d  = 1'b0;
          state_d = A_RELEASE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          prod_d  = '0;
          err_d   = 1'b1;
          done_d  = gnt_o;
          strt_d  = 1'b0;
          state_d = A_RELEASE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      A_RELEASE: begin
        // Hold the grant until the multiplier is really back in IDLE.
        if (mul_state_i == ST_IDLE) begin
          gnt_d   = '0;
          busy_d  = 1'b0;
          state_d = A_IDLE;
        end
      end
      default: begin
        gnt_d   = '0;
        busy_d  = 1'b0;
        strt_d  = 1'b0;
        state_d = A_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= A_IDLE;
      ptr_q      <= '0;
      cnt_q      <= '0;
      gnt_o      <= '0;
      done_o     <= '0;
      prod_o     <= '0;
      err_o      <= 1'b0;
      busy_o     <= 1'b0;
      mul_strt_o <= 1'b0;
      mul_a_o    <= '0;
      mul_b_o    <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      gnt_o      <= gnt_d;
      done_o     <= done_d;
      prod_o     <= prod_d;
      err_o      <= err_d;
      busy_o     <= busy_d;
      mul_strt_o <= strt_d;
      mul_a_o    <= a_d;
      mul_b_o    <= b_d;
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// tb/tb_mult_arbiter.sv - randomized and directed bench for mult_arbiter
module tb_mult_arbiter;
  localparam int N_REQ = 4;
  localparam int DATA_W = 8;
  localparam int TIMEOUT_CYC = 16;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PROD0 = 3'd1;
  localparam logic [2:0] ST_PROD1 = 3'd2;
  localparam logic [2:0] ST_END = 3'd5;

  logic                    clk_i = 1'b0;
  logic                    rst_i = 1'b0;
  logic [N_REQ-1:0]        req_i = '0;
  logic [N_REQ*DATA_W-1:0] a_i = '0;
  logic [N_REQ*DATA_W-1:0] b_i = '0;
  logic [N_REQ-1:0]        gnt_o, done_o;
  logic [2*DATA_W-1:0]     prod_o;
  logic                    err_o, busy_o, mul_strt_o;
  logic [DATA_W-1:0]       mul_a_o, mul_b_o;
  logic [2:0]              mul_state_i;
  logic [2*DATA_W-1:0]     mul_prod_i;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  mult_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .a_i(a_i), .b_i(b_i),
    .gnt_o(gnt_o), .done_o(done_o), .prod_o(prod_o), .err_o(err_o), .busy_o(busy_o),
    .mul_strt_o(mul_strt_o), .mul_a_o(mul_a_o), .mul_b_o(mul_b_o),
    .mul_state_i(mul_state_i), .mul_prod_i(mul_prod_i)
  );

  always #5 clk_i = ~clk_i;

  // Multiplier stand-in: IDLE -> PROD0..3 -> END, back to IDLE once start drops.
  logic [2:0] mul_q;
  logic       mul_force = 1'b0;
  logic [2:0] mul_force_val = ST_IDLE;
  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) mul_q <= ST_IDLE;
    else begin
      case (mul_q)
        ST_IDLE: if (mul_strt_o) mul_q <= ST_PROD0;
        ST_END:  if (!mul_strt_o) mul_q <= ST_IDLE;
        default: mul_q <= mul_q + 3'd1;
      endcase
    end
  end
  assign mul_state_i = mul_force ? mul_force_val : mul_q;
  assign mul_prod_i  = 16'(mul_a_o) * 16'(mul_b_o);

  // Transaction-level reference: owner, cycles since grant, finished flag.
  int         m_owner, m_ptr, m_t;
  bit         m_fin, m_err;
  logic [15:0] m_prod;
  logic [7:0]  m_a, m_b;
  logic [3:0]  m_done;
  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_owner = -1; m_ptr = 0; m_t = 0; m_fin = 0; m_err = 0;
      m_prod = '0; m_a = '0; m_b = '0; m_done = '0;
    end else begin
      m_done = '0;
      if (m_owner < 0) begin
        if (mul_state_i == ST_IDLE) begin
          for (int i = 0; i < N_REQ; i++)
            if (m_owner < 0 && req_i[(m_ptr + i) % N_REQ]) m_owner = (m_ptr + i) % N_REQ;
          if (m_owner >= 0) begin
            m_a = a_i[m_owner*DATA_W +: DATA_W];
            m_b = b_i[m_owner*DATA_W +: DATA_W];
            m_ptr = (m_owner + 1) % N_REQ;
            m_t = 1;
            m_fin = 0;
          end
        end
      end else if (!m_fin) begin
        if (mul_state_i == ST_END) begin
          m_prod = 16'(m_a) * 16'(m_b);
          m_fin = 1;
          m_done[m_owner] = 1'b1;
        end else if (m_t == TIMEOUT_CYC) begin
          m_prod = '0;
          m_err = 1;
          m_fin = 1;
          m_done[m_owner] = 1'b1;
        end else m_t++;
      end else if (mul_state_i == ST_IDLE) begin
        m_owner = -1;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic compare_model();
    check_eq("gnt", 32'(gnt_o), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
    check_eq("done", 32'(done_o), 32'(m_done));
    check_eq("prod", 32'(prod_o), 32'(m_prod));
    check_eq("err", 32'(err_o), 32'(m_err));
    check_eq("busy", 32'(busy_o), 32'(m_owner >= 0));
    check_eq("strt", 32'(mul_strt_o), 32'(m_owner >= 0 && !m_fin));
    check_eq("mul_a", 32'(mul_a_o), 32'(m_a));
    check_eq("mul_b", 32'(mul_b_o), 32'(m_b));
  endtask

  task automatic step();
    @(negedge clk_i);
    cyc++;
    compare_model();
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy_o !== 1'b0 || mul_state_i !== ST_IDLE) && n < 100) begin
      step();
      n++;
    end
    check_eq("idle_reached", 32'(busy_o), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_gnt"}, 32'(gnt_o), 32'd0);
    check_eq({tag, "_done"}, 32'(done_o), 32'd0);
    check_eq({tag, "_prod"}, 32'(prod_o), 32'd0);
    check_eq({tag, "_err"}, 32'(err_o), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy_o), 32'd0);
    check_eq({tag, "_strt"}, 32'(mul_strt_o), 32'd0);
    check_eq({tag, "_a"}, 32'(mul_a_o), 32'd0);
    check_eq({tag, "_b"}, 32'(mul_b_o), 32'd0);
  endtask

  task automatic run_single(input int k, input logic [7:0] a, input logic [7:0] b,
                            input logic [15:0] p);
    logic [3:0] one;
    one = 4'b0001 << k;
    wait_idle();
    req_i = one;
    a_i[k*DATA_W +: DATA_W] = a;
    b_i[k*DATA_W +: DATA_W] = b;
    step();
    req_i = '0;
    check_eq("single_gnt_c1", 32'(gnt_o), 32'(one));
    check_eq("single_strt_c1", 32'(mul_strt_o), 32'd1);
    repeat (5) begin
      step();
      check_eq("single_no_early_done", 32'(done_o), 32'd0);
    end
    step();
    check_eq("single_done_c7", 32'(done_o), 32'(one));
    check_eq("single_prod_c7", 32'(prod_o), 32'(p));
    check_eq("single_strt_c7", 32'(mul_strt_o), 32'd0);
    step();
    step();
    check_eq("single_gnt_c9", 32'(gnt_o), 32'd0);
    check_eq("single_prod_hold", 32'(prod_o), 32'(p));
  endtask

  initial begin
    int rec_cyc[8];
    int rec_idx[8];
    int n_rec, n_done, c0;
    logic [3:0] prev_gnt;

    // Asynchronous reset between edges
    #2 rst_i = 1'b1;
    #1 check_all_zero("reset");
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    wait_idle();

    // Round robin from ptr 0
    req_i = 4'b1111;
    n_rec = 0; n_done = 0; prev_gnt = '0;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (gnt_o != 0 && gnt_o != prev_gnt && n_rec < 8) begin
        rec_cyc[n_rec] = c;
        for (int j = 0; j < N_REQ; j++) if (gnt_o[j]) rec_idx[n_rec] = j;
        n_rec++;
      end
      prev_gnt = gnt_o;
      if (done_o != 0) begin
        n_done++;
        check_eq("rr_done_onehot", 32'($onehot(done_o)), 32'd1);
      end
    end
    req_i = '0;
    check_eq("rr_count", 32'(n_rec >= 5), 32'd1);
    check_eq("rr_dones", 32'(n_done), 32'd4);
    for (int j = 0; j < 5 && j < n_rec; j++) begin
      check_eq("rr_cycle", 32'(rec_cyc[j]), 32'(1 + 9 * j));
      check_eq("rr_index", 32'(rec_idx[j]), 32'(j % 4));
    end

    // Single transactions, typical and maximum operands
    run_single(2, 8'd13, 8'd11, 16'd143);
    run_single(1, 8'hFF, 8'hFF, 16'hFE01);

    // Withdraw request and change operand after the grant
    wait_idle();
    req_i = 4'b0001;
    a_i[7:0] = 8'd7;
    b_i[7:0] = 8'd9;
    step(); step(); step();
    req_i = '0;
    a_i[7:0] = 8'd200;
    b_i[7:0] = 8'd3;
    repeat (4) step();
    check_eq("wd_done_c7", 32'(done_o), 32'b0001);
    check_eq("wd_prod_c7", 32'(prod_o), 32'd63);

    // Watchdog: multiplier stuck in PROD1
    wait_idle();
    req_i = 4'b0010;
    a_i[15:8] = 8'd20;
    b_i[15:8] = 8'd30;
    step();
    req_i = '0;
    mul_force = 1'b1;
    mul_force_val = ST_PROD1;
    repeat (TIMEOUT_CYC - 1) step();
    check_eq("wdog_no_done_yet", 32'(done_o), 32'd0);
    step();
    check_eq("wdog_done", 32'(done_o), 32'b0010);
    check_eq("wdog_prod", 32'(prod_o), 32'd0);
    check_eq("wdog_err", 32'(err_o), 32'd1);
    repeat (5) step();
    check_eq("wdog_gnt_held", 32'(gnt_o), 32'b0010);
    mul_force = 1'b0;
    step();
    check_eq("wdog_gnt_release", 32'(gnt_o), 32'd0);
    run_single(3, 8'd5, 8'd6, 16'd30);
    check_eq("err_sticky", 32'(err_o), 32'd1);

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(3) == 0) req_i = 4'($urandom);
      if ($urandom_range(1) == 0) a_i = $urandom;
      if ($urandom_range(1) == 0) b_i = $urandom;
      step();
    end
    req_i = '0;
    wait_idle();

    // Reset in the middle of a transaction
    req_i = 4'b0100;
    c0 = cyc;
    step();
    req_i = '0;
    repeat (3) step();
    check_eq("midrst_at_c4", 32'(cyc - c0), 32'd4);
    #1 rst_i = 1'b1;
    #1 check_all_zero("midrst");
    #2 rst_i = 1'b0;
    req_i = 4'b1111;
    step();
    check_eq("midrst_next_gnt", 32'(gnt_o), 32'b0001);
    req_i = '0;
    n_done = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (done_o[2]) n_done++;
    end
    check_eq("midrst_no_stale_done", 32'(n_done), 32'd0);
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
